// File: rtl/arp_lut_lookup.sv
// arp_lut_lookup
// Next-hop resolution stage that sits after the LPM stage. It maps the
// next-hop IP to a destination MAC through a small register-programmed
// associative table. It accepts one lookup per cycle and returns each
// result exactly two cycles later. There is no stall path.
//
// Table programming handshake (read port and write port alike):
//   A request is accepted on any clock edge where req=1 and ack=0.
//   The ack is a one-cycle pulse in the cycle after acceptance.
//   A requester that keeps req high is therefore served every other cycle.
//   Read data is registered together with the ack and holds until the next read.
//   A write updates the entry at the acceptance edge. A read accepted at the
//   same edge returns the contents from before that write.

module arp_lut_lookup #(
  parameter int NUM_QUEUES     = 5,
  parameter int LUT_DEPTH      = 32,
  parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,

  // lookup request from the LPM stage
  input  logic [31:0]               next_hop_ip,
  input  logic [NUM_QUEUES-1:0]     lpm_output_port,
  input  logic                      lpm_vld,
  input  logic                      lpm_hit,

  // lookup result towards header rewrite
  output logic [47:0]               next_hop_mac,
  output logic [NUM_QUEUES-1:0]     output_port,
  output logic                      arp_mac_vld,
  output logic                      arp_lookup_hit,
  output logic                      lpm_lookup_hit,
  output logic [31:0]               arp_miss_cnt,

  // register-block read port
  input  logic [LUT_DEPTH_BITS-1:0] arp_rd_addr,
  input  logic                      arp_rd_req,
  output logic [31:0]               arp_rd_ip,
  output logic [47:0]               arp_rd_mac,
  output logic                      arp_rd_ack,

  // register-block write port
  input  logic [LUT_DEPTH_BITS-1:0] arp_wr_addr,
  input  logic                      arp_wr_req,
  input  logic [31:0]               arp_wr_ip,
  input  logic [47:0]               arp_wr_mac,
  output logic                      arp_wr_ack
);

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic [31:0] tbl_ip_q  [LUT_DEPTH];
  logic [47:0] tbl_mac_q [LUT_DEPTH];
  logic [31:0] tbl_ip_d  [LUT_DEPTH];
  logic [47:0] tbl_mac_d [LUT_DEPTH];

  logic        wr_ack_q;
  logic        rd_ack_q;
  logic [31:0] rd_ip_q;
  logic [47:0] rd_mac_q;

  logic        wr_accept;
  logic        rd_accept;

  assign wr_accept = arp_wr_req & ~wr_ack_q;
  assign rd_accept = arp_rd_req & ~rd_ack_q;

  // Next table contents: the accepted write lands on its entry at this edge
  always_comb begin
    for (int i = 0; i < LUT_DEPTH; i++) begin
      tbl_ip_d[i]  = tbl_ip_q[i];
      tbl_mac_d[i] = tbl_mac_q[i];
    end
    if (wr_accept) begin
      tbl_ip_d[arp_wr_addr]  = arp_wr_ip;
      tbl_mac_d[arp_wr_addr] = arp_wr_mac;
    end
  end

  // Table registers; reset empties every entry (ip == 0 means empty)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        tbl_ip_q[i]  <= '0;
        tbl_mac_q[i] <= '0;
      end
    end else begin
      tbl_ip_q  <= tbl_ip_d;
      tbl_mac_q <= tbl_mac_d;
    end
  end

  // Write ack pulse; a request pending at reset is simply dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_accept;
    end
  end

  // Read port; samples pre-write contents so a same-edge write is not visible
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack_q <= 1'b0;
      rd_ip_q  <= '0;
      rd_mac_q <= '0;
    end else begin
      rd_ack_q <= rd_accept;
      if (rd_accept) begin
        rd_ip_q  <= tbl_ip_q[arp_rd_addr];
        rd_mac_q <= tbl_mac_q[arp_rd_addr];
      end
    end
  end

  assign arp_wr_ack = wr_ack_q;
  assign arp_rd_ack = rd_ack_q;
  assign arp_rd_ip  = rd_ip_q;
  assign arp_rd_mac = rd_mac_q;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the LPM result
  // ---------------------------------------------------------------------------
  logic                  s1_vld_q;
  logic [31:0]           s1_ip_q;
  logic [NUM_QUEUES-1:0] s1_port_q;
  logic                  s1_hit_q;

  // Valid bit follows lpm_vld; data only loads on a valid strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_ip_q   <= '0;
      s1_port_q <= '0;
      s1_hit_q  <= 1'b0;
    end else begin
      s1_vld_q <= lpm_vld;
      if (lpm_vld) begin
        s1_ip_q   <= next_hop_ip;
        s1_port_q <= lpm_output_port;
        s1_hit_q  <= lpm_hit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: associative compare, lowest index wins
  // ---------------------------------------------------------------------------
  // The compare uses the next table contents. A write accepted at the same
  // edge as this result is registered is therefore already seen.
  logic        match_any;
  logic [47:0] match_mac;

  // Priority search: scanning downward lets the lowest matching index win
  always_comb begin
    match_any = 1'b0;
    match_mac = '0;
    for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
      if ((tbl_ip_d[i] != '0) && (tbl_ip_d[i] == s1_ip_q)) begin
        match_any = 1'b1;
        match_mac = tbl_mac_d[i];
      end
    end
  end

  logic [47:0]           mac_q,   mac_d;
  logic [NUM_QUEUES-1:0] port_q,  port_d;
  logic                  vld_q,   vld_d;
  logic                  ahit_q,  ahit_d;
  logic                  lhit_q,  lhit_d;
  logic [31:0]           miss_q,  miss_d;

  // Result next-state; everything but the strobe holds when no result is due
  always_comb begin
    mac_d  = mac_q;
    port_d = port_q;
    ahit_d = ahit_q;
    lhit_d = lhit_q;
    miss_d = miss_q;
    vld_d  = s1_vld_q;
    if (s1_vld_q) begin
      port_d = s1_port_q;
      lhit_d = s1_hit_q;
      ahit_d = s1_hit_q & match_any;
      mac_d  = (s1_hit_q && match_any) ? match_mac : 48'd0;
      if (s1_hit_q && !match_any && (miss_q != 32'hFFFF_FFFF)) begin
        miss_d = miss_q + 32'd1;
      end
    end
  end

  // Result registers; reset also discards any lookup still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_q  <= '0;
      port_q <= '0;
      vld_q  <= 1'b0;
      ahit_q <= 1'b0;
      lhit_q <= 1'b0;
      miss_q <= '0;
    end else begin
      mac_q  <= mac_d;
      port_q <= port_d;
      vld_q  <= vld_d;
      ahit_q <= ahit_d;
      lhit_q <= lhit_d;
      miss_q <= miss_d;
    end
  end

  assign next_hop_mac   = mac_q;
  assign output_port    = port_q;
  assign arp_mac_vld    = vld_q;
  assign arp_lookup_hit = ahit_q;
  assign lpm_lookup_hit = lhit_q;
  assign arp_miss_cnt   = miss_q;

endmodule

// File: tb/tb_arp_lut_lookup.sv
// Testbench for arp_lut_lookup. It runs directed scenarios followed by
// randomized traffic. The expected results come from a table-level reference
// model through a scoreboard queue.

module tb_arp_lut_lookup;

  localparam int NQ = 5;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          reset;
  logic [31:0]   next_hop_ip;
  logic [NQ-1:0] lpm_output_port;
  logic          lpm_vld;
  logic          lpm_hit;
  logic [47:0]   next_hop_mac;
  logic [NQ-1:0] output_port;
  logic          arp_mac_vld;
  logic          arp_lookup_hit;
  logic          lpm_lookup_hit;
  logic [31:0]   arp_miss_cnt;
  logic [AW-1:0] arp_rd_addr;
  logic          arp_rd_req;
  logic [31:0]   arp_rd_ip;
  logic [47:0]   arp_rd_mac;
  logic          arp_rd_ack;
  logic [AW-1:0] arp_wr_addr;
  logic          arp_wr_req;
  logic [31:0]   arp_wr_ip;
  logic [47:0]   arp_wr_mac;
  logic          arp_wr_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arp_lut_lookup #(.NUM_QUEUES(NQ), .LUT_DEPTH(DEPTH), .LUT_DEPTH_BITS(AW)) dut (
    .clk(clk), .reset(reset),
    .next_hop_ip(next_hop_ip), .lpm_output_port(lpm_output_port),
    .lpm_vld(lpm_vld), .lpm_hit(lpm_hit),
    .next_hop_mac(next_hop_mac), .output_port(output_port),
    .arp_mac_vld(arp_mac_vld), .arp_lookup_hit(arp_lookup_hit),
    .lpm_lookup_hit(lpm_lookup_hit), .arp_miss_cnt(arp_miss_cnt),
    .arp_rd_addr(arp_rd_addr), .arp_rd_req(arp_rd_req),
    .arp_rd_ip(arp_rd_ip), .arp_rd_mac(arp_rd_mac), .arp_rd_ack(arp_rd_ack),
    .arp_wr_addr(arp_wr_addr), .arp_wr_req(arp_wr_req),
    .arp_wr_ip(arp_wr_ip), .arp_wr_mac(arp_wr_mac), .arp_wr_ack(arp_wr_ack)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: table contents, handshakes, lookups resolved one edge
  // after capture against the table as it stands after that edge's write
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [47:0]   mac;
    logic [NQ-1:0] port;
    logic          ahit;
    logic          lhit;
    logic [31:0]   miss;
  } res_t;

  res_t          exp_q[$];
  logic [79:0]   rd_exp_q[$];
  logic [31:0]   m_ip  [DEPTH];
  logic [47:0]   m_mac [DEPTH];
  logic          m_rd_ack = 1'b0;
  logic          m_wr_ack = 1'b0;
  logic [31:0]   m_miss = '0;
  logic          pend_v = 1'b0;
  logic [31:0]   pend_ip;
  logic [NQ-1:0] pend_port;
  logic          pend_hit;
  int            rst_gen = 0;

  always @(posedge clk) begin
    if (reset) begin
      foreach (m_ip[i]) begin m_ip[i] = '0; m_mac[i] = '0; end
      m_rd_ack = 1'b0;
      m_wr_ack = 1'b0;
      m_miss   = '0;
      pend_v   = 1'b0;
      exp_q.delete();
      rd_exp_q.delete();
      rst_gen++;
    end else begin
      logic rd_acc, wr_acc, found;
      logic [47:0] fmac;
      res_t r;
      rd_acc = arp_rd_req && !m_rd_ack;
      wr_acc = arp_wr_req && !m_wr_ack;
      if (rd_acc) rd_exp_q.push_back({m_ip[arp_rd_addr], m_mac[arp_rd_addr]});
      if (wr_acc) begin
        m_ip[arp_wr_addr]  = arp_wr_ip;
        m_mac[arp_wr_addr] = arp_wr_mac;
      end
      m_rd_ack = rd_acc;
      m_wr_ack = wr_acc;
      if (pend_v) begin
        found = 1'b0;
        fmac  = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && m_ip[i] != 0 && m_ip[i] == pend_ip) begin
            found = 1'b1;
            fmac  = m_mac[i];
          end
        end
        if (pend_hit && !found && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
        r.mac  = (pend_hit && found) ? fmac : 48'd0;
        r.port = pend_port;
        r.ahit = pend_hit && found;
        r.lhit = pend_hit;
        r.miss = m_miss;
        exp_q.push_back(r);
      end
      pend_v    = lpm_vld;
      pend_ip   = next_hop_ip;
      pend_port = lpm_output_port;
      pend_hit  = lpm_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: pops on each DUT strobe, checks held values otherwise
  // ---------------------------------------------------------------------------
  res_t        last;
  logic [79:0] rd_last;
  int          seen_gen = 0;

  always @(negedge clk) begin
    if (rst_gen != 0) begin
      if (rst_gen != seen_gen) begin
        last     = '0;
        rd_last  = '0;
        seen_gen = rst_gen;
      end
      if (arp_mac_vld) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_vld", 64'(arp_mac_vld), 64'd0);
        end else begin
          last = exp_q.pop_front();
        end
      end else if (exp_q.size() > 0) begin
        check("sb_missing_vld", 64'(arp_mac_vld), 64'd1);
        void'(exp_q.pop_front());
      end
      check("sb_mac",  64'(next_hop_mac),   64'(last.mac));
      check("sb_port", 64'(output_port),    64'(last.port));
      check("sb_ahit", 64'(arp_lookup_hit), 64'(last.ahit));
      check("sb_lhit", 64'(lpm_lookup_hit), 64'(last.lhit));
      check("sb_miss", 64'(arp_miss_cnt),   64'(last.miss));
      check("sb_wr_ack", 64'(arp_wr_ack), 64'(m_wr_ack));
      check("sb_rd_ack", 64'(arp_rd_ack), 64'(m_rd_ack));
      if (arp_rd_ack) begin
        if (rd_exp_q.size() == 0) check("sb_rd_unexpected", 64'(arp_rd_ack), 64'd0);
        else rd_last = rd_exp_q.pop_front();
      end
      check("sb_rd_ip",  64'(arp_rd_ip),  64'(rd_last[79:48]));
      check("sb_rd_mac", 64'(arp_rd_mac), 64'(rd_last[47:0]));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] ip, input logic [47:0] mac);
    @(negedge clk);
    arp_wr_addr = a; arp_wr_ip = ip; arp_wr_mac = mac; arp_wr_req = 1'b1;
    @(negedge clk);
    check("wr_ack_latency", 64'(arp_wr_ack), 64'd1);
    arp_wr_req = 1'b0;
  endtask

  task automatic do_read_chk(input logic [AW-1:0] a, input logic [31:0] eip, input logic [47:0] emac);
    @(negedge clk);
    arp_rd_addr = a; arp_rd_req = 1'b1;
    @(negedge clk);
    check("rd_ack_latency", 64'(arp_rd_ack), 64'd1);
    check("rd_ip",  64'(arp_rd_ip),  64'(eip));
    check("rd_mac", 64'(arp_rd_mac), 64'(emac));
    arp_rd_req = 1'b0;
  endtask

  // Single lookup with an exact two-cycle latency check
  task automatic lookup_chk(input logic [31:0] ip, input logic [NQ-1:0] port, input logic hit,
                            input logic [47:0] emac, input logic eahit);
    @(negedge clk);
    next_hop_ip = ip; lpm_output_port = port; lpm_hit = hit; lpm_vld = 1'b1;
    @(negedge clk);
    lpm_vld = 1'b0; lpm_hit = 1'b0;
    check("lat_not_early", 64'(arp_mac_vld), 64'd0);
    @(negedge clk);
    check("lat_vld",  64'(arp_mac_vld),    64'd1);
    check("res_mac",  64'(next_hop_mac),   64'(emac));
    check("res_port", 64'(output_port),    64'(port));
    check("res_ahit", 64'(arp_lookup_hit), 64'(eahit));
    check("res_lhit", 64'(lpm_lookup_hit), 64'(hit));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] ip_pool [8] = '{32'h0, 32'h0A000001, 32'h0C000002, 32'h01020304,
                               32'h0A0A0A0A, 32'hC0A80001, 32'hC0A80002, 32'hFFFFFFFF};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    logic [31:0] b2b_ip  [4] = '{32'h0A000001, 32'h0B000000, 32'h0A000001, 32'h0A000001};
    logic        b2b_hit [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [47:0] b2b_mac [4] = '{48'h001122334455, 48'h0, 48'h0, 48'h001122334455};
    logic        b2b_ah  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    next_hop_ip = '0; lpm_output_port = '0; lpm_vld = 1'b0; lpm_hit = 1'b0;
    arp_rd_addr = '0; arp_rd_req = 1'b0;
    arp_wr_addr = '0; arp_wr_req = 1'b0; arp_wr_ip = '0; arp_wr_mac = '0;
    repeat (3) @(negedge clk);
    check("rst_vld",  64'(arp_mac_vld),  64'd0);
    check("rst_miss", 64'(arp_miss_cnt), 64'd0);
    check("rst_mac",  64'(next_hop_mac), 64'd0);
    reset = 1'b0;

    // ip 0 on an empty table never matches and counts as a miss
    lookup_chk(32'h0, 5'b00001, 1'b1, 48'h0, 1'b0);
    check("miss_after_ip0", 64'(arp_miss_cnt), 64'd1);

    // basic hit
    do_write(5'd3, 32'h0A000001, 48'h001122334455);
    lookup_chk(32'h0A000001, 5'b00100, 1'b1, 48'h001122334455, 1'b1);

    // duplicate IP: lowest index wins
    do_write(5'd7, 32'h0C000002, 48'hAAAAAAAAAAAA);
    do_write(5'd2, 32'h0C000002, 48'hBBBBBBBBBBBB);
    lookup_chk(32'h0C000002, 5'b01000, 1'b1, 48'hBBBBBBBBBBBB, 1'b1);

    // four back-to-back lookups: hit, miss, no lpm hit, hit
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 5) begin
        check("b2b_vld",  64'(arp_mac_vld),    64'd1);
        check("b2b_mac",  64'(next_hop_mac),   64'(b2b_mac[k-2]));
        check("b2b_ahit", 64'(arp_lookup_hit), 64'(b2b_ah[k-2]));
        check("b2b_lhit", 64'(lpm_lookup_hit), 64'(b2b_hit[k-2]));
      end
      if (k == 6) check("b2b_vld_end", 64'(arp_mac_vld), 64'd0);
      if (k < 4) begin
        next_hop_ip = b2b_ip[k]; lpm_hit = b2b_hit[k];
        lpm_output_port = NQ'(k + 1); lpm_vld = 1'b1;
      end else begin
        lpm_vld = 1'b0; lpm_hit = 1'b0;
      end
    end
    check("b2b_miss_cnt", 64'(arp_miss_cnt), 64'd2);

    // concurrent read and write of the same entry: read sees old contents
    @(negedge clk);
    arp_rd_addr = 5'd3; arp_rd_req = 1'b1;
    arp_wr_addr = 5'd3; arp_wr_ip = 32'h0A000001; arp_wr_mac = 48'h665544332211; arp_wr_req = 1'b1;
    @(negedge clk);
    check("rw_rd_ack", 64'(arp_rd_ack), 64'd1);
    check("rw_wr_ack", 64'(arp_wr_ack), 64'd1);
    check("rw_rd_old", 64'(arp_rd_mac), 64'h001122334455);
    arp_rd_req = 1'b0; arp_wr_req = 1'b0;
    do_read_chk(5'd3, 32'h0A000001, 48'h665544332211);

    // held read request is served every other cycle
    @(negedge clk);
    arp_rd_addr = 5'd2; arp_rd_req = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (arp_rd_ack) acks++;
    end
    arp_rd_req = 1'b0;
    check("rd_held_acks", 64'(acks), 64'd3);
    check("rd_held_mac",  64'(arp_rd_mac), 64'hBBBBBBBBBBBB);

    // reset one cycle after a lookup drops it and clears the table
    @(negedge clk);
    next_hop_ip = 32'h0A000001; lpm_output_port = 5'b10000; lpm_hit = 1'b1; lpm_vld = 1'b1;
    @(negedge clk);
    lpm_vld = 1'b0; lpm_hit = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst_mid_vld",  64'(arp_mac_vld),    64'd0);
    check("rst_mid_mac",  64'(next_hop_mac),   64'd0);
    check("rst_mid_port", 64'(output_port),    64'd0);
    check("rst_mid_ahit", 64'(arp_lookup_hit), 64'd0);
    check("rst_mid_lhit", 64'(lpm_lookup_hit), 64'd0);
    check("rst_mid_miss", 64'(arp_miss_cnt),   64'd0);
    check("rst_mid_rdmac", 64'(arp_rd_mac),    64'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_late_vld", 64'(arp_mac_vld), 64'd0);
    end
    lookup_chk(32'h0A000001, 5'b00100, 1'b1, 48'h0, 1'b0);
    check("rst_table_miss_cnt", 64'(arp_miss_cnt), 64'd1);

    // randomized traffic on all three ports at once
    fork
      begin
        repeat (400) begin
          @(negedge clk);
          lpm_vld         = ($urandom_range(0, 3) != 0);
          lpm_hit         = ($urandom_range(0, 4) != 0);
          next_hop_ip     = ip_pool[$urandom_range(0, 7)];
          lpm_output_port = NQ'(1 << $urandom_range(0, NQ - 1));
        end
        lpm_vld = 1'b0;
      end
      begin
        repeat (400) begin
          @(negedge clk);
          arp_wr_req  = ($urandom_range(0, 3) == 0);
          arp_wr_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                    : AW'($urandom_range(0, 7));
          arp_wr_ip   = ip_pool[$urandom_range(0, 7)];
          arp_wr_mac  = {16'($urandom), $urandom};
        end
        arp_wr_req = 1'b0;
      end
      begin
        repeat (400) begin
          @(negedge clk);
          arp_rd_req  = ($urandom_range(0, 2) == 0);
          arp_rd_addr = AW'($urandom_range(0, 7));
        end
        arp_rd_req = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    check("sb_exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("sb_rd_q_drained",  64'(rd_exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arp_lut_lookup.md
# arp_lut_lookup

Next-hop resolution stage directly downstream of the IP longest-prefix-match stage in the router output-port-lookup pipeline. Consumes the LPM result (next-hop IP, output port, valid/hit), resolves next-hop IP to a 48-bit destination MAC through a register-programmed associative table, and presents MAC, port and hit flags to the header-rewrite logic. Fully pipelined: accepts one lookup per cycle with fixed 2-cycle latency. Table read/write ports face the register block.

## Interface
- NUM_QUEUES, 5, output-port one-hot width (matches LPM stage)
- LUT_DEPTH, 32, number of ARP entries
- LUT_DEPTH_BITS, log2(LUT_DEPTH), table address width
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- next_hop_ip  in  32  next-hop IP from LPM stage
- lpm_output_port  in  NUM_QUEUES  output port from LPM stage
- lpm_vld  in  1  one-cycle strobe: LPM result valid
- lpm_hit  in  1  LPM found a route (qualified by lpm_vld)
- next_hop_mac  out  48  resolved MAC; 0 on miss
- output_port  out  NUM_QUEUES  lpm_output_port passed through, aligned with result
- arp_mac_vld  out  1  one-cycle strobe: result valid
- arp_lookup_hit  out  1  ARP entry matched
- lpm_lookup_hit  out  1  lpm_hit passed through, aligned
- arp_miss_cnt  out  32  saturating count of LPM-hit/ARP-miss lookups
- arp_rd_addr  in  LUT_DEPTH_BITS;  arp_rd_req  in  1;  arp_rd_ip  out  32;  arp_rd_mac  out  48;  arp_rd_ack  out  1
- arp_wr_addr  in  LUT_DEPTH_BITS;  arp_wr_req  in  1;  arp_wr_ip  in  32;  arp_wr_mac  in  48;  arp_wr_ack  out  1

## Operation
- Table: LUT_DEPTH entries of {ip[31:0], mac[47:0]} in registers. Entry with ip == 0 is empty and never matches.
- Stage 1 (edge T, lpm_vld=1): register next_hop_ip, lpm_output_port, lpm_hit, valid bit. lpm_vld=0 -> stage-1 valid bit 0; data regs may hold.
- Stage 2 (edge T+1): parallel compare of stage-1 IP against all entries; lowest matching index wins; MAC muxed in the same cycle and registered with outputs.
- Outputs at T+1 edge -> visible cycle T+2... stated precisely: arp_mac_vld asserted in the cycle after the edge following lpm_vld sampling, i.e. 2 cycles after lpm_vld high.
- arp_lookup_hit = stage-1 lpm_hit AND any match. lpm_hit=0 -> arp_lookup_hit=0, next_hop_mac=0, arp_miss_cnt unchanged.
- arp_miss_cnt increments by 1 when result valid, lpm_hit=1, no match; holds at 32'hFFFF_FFFF.
- Outputs other than arp_mac_vld hold last value when no result is valid.
- Write: request accepted on any cycle arp_wr_req=1 and arp_wr_ack=0; entry updated at that edge; arp_wr_ack pulses 1 cycle next cycle. Requester drops req on ack; held req -> one write every 2 cycles.
- Read: same accept rule with arp_rd_ack; arp_rd_ip/arp_rd_mac registered with the ack, holding until next read.
- Read and write same address same edge: read returns pre-write contents.

## Timing
- Lookup latency 2 cycles, throughput 1/cycle, no backpressure, no stall.
- Write at edge E visible to compare for stage-1 entries compared during cycle after E (lookup sampled at edge E-1 or later sees new entry; sampled at E-2 or earlier sees old).
- Read/write ack latency 1 cycle; read and write ports independent of each other and of lookups.
- Reset: all table entries cleared to 0; next_hop_mac=0, output_port=0, arp_mac_vld=0, arp_lookup_hit=0, lpm_lookup_hit=0, arp_miss_cnt=0, arp_rd_ip=0, arp_rd_mac=0, arp_rd_ack=0, arp_wr_ack=0. Reset mid-lookup drops in-flight results (no arp_mac_vld after reset deasserts for pre-reset inputs); request pending at reset is dropped without ack.

## Test plan
- Write idx 3 {ip=0A000001, mac=001122334455}, wr_ack 1 cycle later; lpm_vld/lpm_hit=1, ip=0A000001, port=5'b00100 -> 2 cycles later arp_mac_vld=1, hit=1, mac=001122334455, output_port=00100.
- Same IP in idx 7 (mac AA..AA) and idx 2 (mac BB..BB) -> mac=BBBBBBBBBBBB (lowest index).
- Back-to-back lookups on 4 consecutive cycles (hit, miss, lpm_hit=0, hit) -> 4 consecutive arp_mac_vld strobes, correct order; arp_miss_cnt +1 only.
- Lookup ip=00000000 on reset table with lpm_hit=1 -> hit=0, mac=0, arp_miss_cnt=1.
- Read idx 3 concurrently with write idx 3 new mac -> rd_mac=old value; subsequent read -> new value; held rd_req yields ack every other cycle.
- Reset asserted one cycle after lpm_vld -> no arp_mac_vld, all outputs 0, table lookup after reset misses.
